// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl shared types: sequencer states, commit kind, cause codes.
// Imported by the trap sequencer and its cause encoder.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  typedef enum logic {
    K_TRAP = 1'b0,
    K_RET  = 1'b1
  } kind_e;

  localparam int unsigned CAUSE_ECALL_M  = 11;
  localparam int unsigned CAUSE_EBREAK   = 3;
  localparam int unsigned CAUSE_MTI_CODE = 7;

  // mcause for the machine timer interrupt: interrupt flag in the MSB
  function automatic logic [63:0] cause_mti(input int unsigned w);
    logic [63:0] c;
    c = 64'(CAUSE_MTI_CODE);
    c[w-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Writeback/CSR/fetch-side bundle around the trap sequencer.
// master = pipeline side, slave = trap_ctrl.
interface trap_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_pc;
  logic              wb_ecall;
  logic              wb_ebreak;
  logic              wb_mret;
  logic              clint_mtip;
  logic              mstatus_mie;
  logic              mie_mtie;
  logic [DATA_W-1:0] mtvec;
  logic [DATA_W-1:0] mepc;
  logic              mem_busy;

  logic              stall;
  logic              flush;
  logic              trap_en;
  logic              ret_en;
  logic [DATA_W-1:0] trap_cause;
  logic [ADDR_W-1:0] trap_epc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output wb_valid, wb_pc, wb_ecall, wb_ebreak, wb_mret,
    output clint_mtip, mstatus_mie, mie_mtie,
    output mtvec, mepc, mem_busy,
    input  stall, flush, trap_en, ret_en,
    input  trap_cause, trap_epc,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  wb_valid, wb_pc, wb_ecall, wb_ebreak, wb_mret,
    input  clint_mtip, mstatus_mie, mie_mtie,
    input  mtvec, mepc, mem_busy,
    output stall, flush, trap_en, ret_en,
    output trap_cause, trap_epc,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_cause_enc.sv
// Combinational priority encoder for retiring trap/return events.
// ecall > ebreak > mret > timer interrupt.
module trap_cause_enc
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              wb_valid,
  input  logic              wb_ecall,
  input  logic              wb_ebreak,
  input  logic              wb_mret,
  input  logic              irq,
  input  logic [ADDR_W-1:0] wb_pc,
  output logic              accept,
  output kind_e             kind,
  output logic [DATA_W-1:0] cause,
  output logic [ADDR_W-1:0] epc
);

  localparam logic [63:0] MTI = cause_mti(DATA_W);

  always_comb begin
    accept = 1'b0;
    kind   = K_TRAP;
    cause  = '0;
    epc    = '0;
    if (wb_valid) begin
      priority case (1'b1)
        wb_ecall: begin
          accept = 1'b1;
          cause  = DATA_W'(CAUSE_ECALL_M);
          epc    = wb_pc;
        end
        wb_ebreak: begin
          accept = 1'b1;
          cause  = DATA_W'(CAUSE_EBREAK);
          epc    = wb_pc;
        end
        wb_mret: begin
          accept = 1'b1;
          kind   = K_RET;
        end
        // interrupt resumes after the retiring instruction
        irq: begin
          accept = 1'b1;
          cause  = MTI[DATA_W-1:0];
          epc    = wb_pc + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: stall, drain AXI data traffic,
// one-cycle CSR commit strobe, then one-cycle fetch redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  kind_e             kind_q;
  logic [DATA_W-1:0] cause_q;
  logic [ADDR_W-1:0] epc_q;

  logic              irq;
  logic              acc;
  kind_e             acc_kind;
  logic [DATA_W-1:0] acc_cause;
  logic [ADDR_W-1:0] acc_epc;
  logic              take;

  assign irq  = bus.clint_mtip & bus.mstatus_mie
              & bus.mie_mtie;
  assign take = (state_q == S_IDLE) & acc;

  trap_cause_enc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_enc (
    .wb_valid  (bus.wb_valid),
    .wb_ecall  (bus.wb_ecall),
    .wb_ebreak (bus.wb_ebreak),
    .wb_mret   (bus.wb_mret),
    .irq       (irq),
    .wb_pc     (bus.wb_pc),
    .accept    (acc),
    .kind      (acc_kind),
    .cause     (acc_cause),
    .epc       (acc_epc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q  <= K_TRAP;
      cause_q <= '0;
      epc_q   <= '0;
    end else if (take) begin
      kind_q  <= acc_kind;
      cause_q <= acc_cause;
      epc_q   <= acc_epc;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = bus.mem_busy ? S_DRAIN
                                 : S_COMMIT;
        end
      end
      S_DRAIN: begin
        if (!bus.mem_busy) state_d = S_COMMIT;
      end
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // strobes decode the state register only
  always_comb begin
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.trap_en        = 1'b0;
    bus.ret_en         = 1'b0;
    bus.trap_cause     = '0;
    bus.trap_epc       = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    unique case (state_q)
      S_IDLE: ;
      S_DRAIN: begin
        bus.stall = 1'b1;
      end
      S_COMMIT: begin
        bus.stall      = 1'b1;
        bus.flush      = 1'b1;
        bus.trap_en    = (kind_q == K_TRAP);
        bus.ret_en     = (kind_q == K_RET);
        bus.trap_cause = cause_q;
        bus.trap_epc   = epc_q;
      end
      S_REDIRECT: begin
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        // CSRs written at the end of COMMIT are visible here
        if (kind_q == K_RET) begin
          bus.redirect_pc = ADDR_W'(bus.mepc);
        end else begin
          bus.redirect_pc =
            ADDR_W'(bus.mtvec & ~DATA_W'(3));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: vector table, corner sequences,
// and a randomized run against a cycle-count reference model.
module tb_trap_ctrl;

  localparam bit T = 1'b1;
  localparam bit F = 1'b0;
  localparam logic [63:0] MTI = 64'h8000_0000_0000_0007;
  localparam logic [63:0] TV  = 64'h8000_0003;
  localparam logic [63:0] EP  = 64'h8000_0200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  trap_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit v, ec, eb, mr, tip, mie, mtie;
    logic [63:0] pc;
    bit et, er;
    logic [63:0] cause, epc, rpc;
  } vec_t;

  vec_t vecs[12];

  task automatic cmp(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.wb_valid    = 1'b0;
    bus.wb_pc       = '0;
    bus.wb_ecall    = 1'b0;
    bus.wb_ebreak   = 1'b0;
    bus.wb_mret     = 1'b0;
    bus.clint_mtip  = 1'b0;
    bus.mstatus_mie = 1'b1;
    bus.mie_mtie    = 1'b1;
    bus.mtvec       = TV;
    bus.mepc        = EP;
    bus.mem_busy    = 1'b0;
  endtask

  function automatic logic [63:0] ctl();
    return {59'd0, bus.stall, bus.flush, bus.trap_en,
            bus.ret_en, bus.redirect_valid};
  endfunction

  function automatic logic [63:0] mk(bit st, bit fl,
                                     bit te, bit re, bit rv);
    return {59'd0, st, fl, te, re, rv};
  endfunction

  // reference model state: accept cycle, commit cycle
  bit          m_act;
  int          m_n;
  int          m_c;
  bit          m_ret;
  logic [63:0] m_cause;
  logic [63:0] m_epc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit any;
    vecs[0]  = '{T,T,F,F,F,T,T,64'h8000_0100,T,F,
                 64'd11,64'h8000_0100,64'h8000_0000};
    vecs[1]  = '{T,F,T,F,F,T,T,64'h8000_0104,T,F,
                 64'd3,64'h8000_0104,64'h8000_0000};
    vecs[2]  = '{T,F,F,T,F,T,T,64'h8000_0108,F,T,
                 64'd0,64'd0,EP};
    vecs[3]  = '{T,F,F,F,T,T,T,64'h8000_0ffc,T,F,
                 MTI,64'h8000_1000,64'h8000_0000};
    vecs[4]  = '{T,F,F,F,T,F,T,64'h8000_0ffc,F,F,
                 64'd0,64'd0,64'd0};
    vecs[5]  = '{T,F,F,F,T,T,F,64'h8000_0ffc,F,F,
                 64'd0,64'd0,64'd0};
    vecs[6]  = '{F,F,F,F,T,T,T,64'h8000_0ffc,F,F,
                 64'd0,64'd0,64'd0};
    vecs[7]  = '{F,T,F,F,F,T,T,64'h8000_0100,F,F,
                 64'd0,64'd0,64'd0};
    vecs[8]  = '{T,F,T,F,T,T,T,64'h8000_0010,T,F,
                 64'd3,64'h8000_0010,64'h8000_0000};
    vecs[9]  = '{T,T,T,T,F,T,T,64'h8000_0020,T,F,
                 64'd11,64'h8000_0020,64'h8000_0000};
    vecs[10] = '{T,F,F,T,T,T,T,64'h8000_0030,F,T,
                 64'd0,64'd0,EP};
    vecs[11] = '{T,F,F,F,T,T,T,64'hFFFF_FFFF_FFFF_FFFC,T,F,
                 MTI,64'd0,64'h8000_0000};

    // reset state
    rst = 1'b1;
    idle_in();
    step();
    step();
    cmp("reset_ctl", ctl(), mk(F,F,F,F,F));
    cmp("reset_cause", bus.trap_cause, 64'd0);
    cmp("reset_rpc", bus.redirect_pc, 64'd0);
    rst = 1'b0;
    step();

    // single-event vectors, no drain
    for (int i = 0; i < 12; i++) begin
      any = vecs[i].et | vecs[i].er;
      idle_in();
      bus.wb_valid    = vecs[i].v;
      bus.wb_ecall    = vecs[i].ec;
      bus.wb_ebreak   = vecs[i].eb;
      bus.wb_mret     = vecs[i].mr;
      bus.clint_mtip  = vecs[i].tip;
      bus.mstatus_mie = vecs[i].mie;
      bus.mie_mtie    = vecs[i].mtie;
      bus.wb_pc       = vecs[i].pc;
      step();
      idle_in();
      cmp($sformatf("vec%0d_commit", i), ctl(),
          mk(any, any, vecs[i].et, vecs[i].er, F));
      cmp($sformatf("vec%0d_cause", i), bus.trap_cause,
          vecs[i].cause);
      cmp($sformatf("vec%0d_epc", i), bus.trap_epc,
          vecs[i].epc);
      step();
      cmp($sformatf("vec%0d_redir", i), ctl(),
          mk(any, F, F, F, any));
      cmp($sformatf("vec%0d_rpc", i), bus.redirect_pc,
          vecs[i].rpc);
      step();
      cmp($sformatf("vec%0d_idle", i), ctl(),
          mk(F,F,F,F,F));
    end

    // mret with mem_busy high for three DRAIN cycles
    idle_in();
    bus.wb_valid = 1'b1;
    bus.wb_mret  = 1'b1;
    bus.mem_busy = 1'b1;
    step();
    bus.wb_valid = 1'b0;
    bus.wb_mret  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("drain%0d", i), ctl(), mk(T,F,F,F,F));
      if (i == 2) bus.mem_busy = 1'b0;
      step();
    end
    cmp("drain_commit", ctl(), mk(T,T,F,T,F));
    step();
    cmp("drain_redir", ctl(), mk(T,F,F,F,T));
    cmp("drain_rpc", bus.redirect_pc, EP);
    step();
    cmp("drain_idle", ctl(), mk(F,F,F,F,F));

    // ebreak beats irq; irq taken back-to-back afterwards
    idle_in();
    bus.wb_valid   = 1'b1;
    bus.wb_ebreak  = 1'b1;
    bus.clint_mtip = 1'b1;
    bus.wb_pc      = 64'h8000_0040;
    step();
    bus.wb_valid  = 1'b0;
    bus.wb_ebreak = 1'b0;
    cmp("prio_cause", bus.trap_cause, 64'd3);
    cmp("prio_commit", ctl(), mk(T,T,T,F,F));
    step();
    cmp("prio_redir", ctl(), mk(T,F,F,F,T));
    bus.wb_valid = 1'b1;
    bus.wb_ecall = 1'b1;
    step();
    cmp("prio_idle", ctl(), mk(F,F,F,F,F));
    bus.wb_ecall = 1'b0;
    bus.wb_pc    = 64'h8000_0080;
    step();
    bus.wb_valid = 1'b0;
    cmp("defer_commit", ctl(), mk(T,T,T,F,F));
    cmp("defer_cause", bus.trap_cause, MTI);
    cmp("defer_epc", bus.trap_epc, 64'h8000_0084);
    idle_in();
    step();
    step();

    // ecall held through COMMIT and REDIRECT: one pulse
    idle_in();
    bus.wb_valid = 1'b1;
    bus.wb_ecall = 1'b1;
    bus.wb_pc    = 64'h8000_0300;
    step();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.trap_en) cnt++;
      if (i == 2) idle_in();
      step();
    end
    cmp("ignored_pulses", 64'(cnt), 64'd1);

    // asynchronous reset in DRAIN aborts the sequence
    idle_in();
    bus.wb_valid = 1'b1;
    bus.wb_ecall = 1'b1;
    bus.mem_busy = 1'b1;
    bus.wb_pc    = 64'h8000_0400;
    step();
    bus.wb_valid = 1'b0;
    bus.wb_ecall = 1'b0;
    cmp("rstd_drain", ctl(), mk(T,F,F,F,F));
    #2;
    rst = 1'b1;
    #1;
    cmp("rstd_async", ctl(), mk(F,F,F,F,F));
    bus.mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.trap_en | bus.redirect_valid | bus.stall)
        cnt++;
    end
    cmp("rstd_quiet", 64'(cnt), 64'd0);

    // randomized run against the reference model
    idle_in();
    step();
    m_act = 1'b0;
    m_n = 0;
    m_c = -1;
    m_ret = 1'b0;
    m_cause = '0;
    m_epc = '0;
    for (int t = 0; t < 1500; t++) begin
      logic [63:0] e_ctl, e_cause, e_epc, e_rpc;
      bit irq;
      if (m_act && m_c >= 0 && t >= m_c + 2) m_act = 1'b0;
      e_ctl = mk(F,F,F,F,F);
      e_cause = '0;
      e_epc = '0;
      e_rpc = '0;
      if (m_act) begin
        if (m_c < 0 || t < m_c) begin
          e_ctl = mk(T,F,F,F,F);
        end else if (t == m_c) begin
          e_ctl = mk(T,T,!m_ret,m_ret,F);
          e_cause = m_cause;
          e_epc = m_epc;
        end else begin
          e_ctl = mk(T,F,F,F,T);
          e_rpc = m_ret ? bus.mepc : (bus.mtvec & ~64'd3);
        end
      end
      cmp("rnd_ctl", ctl(), e_ctl);
      cmp("rnd_cause", bus.trap_cause, e_cause);
      cmp("rnd_epc", bus.trap_epc, e_epc);
      cmp("rnd_rpc", bus.redirect_pc, e_rpc);

      bus.wb_valid    = ($urandom_range(0, 1) == 1);
      bus.wb_ecall    = ($urandom_range(0, 9) == 0);
      bus.wb_ebreak   = ($urandom_range(0, 9) == 0);
      bus.wb_mret     = ($urandom_range(0, 9) == 0);
      bus.clint_mtip  = ($urandom_range(0, 2) == 0);
      bus.mstatus_mie = ($urandom_range(0, 4) != 0);
      bus.mie_mtie    = ($urandom_range(0, 4) != 0);
      bus.mem_busy    = ($urandom_range(0, 2) == 0);
      bus.wb_pc       = {$urandom(), $urandom()} & ~64'd3;
      if ($urandom_range(0, 15) == 0)
        bus.wb_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      bus.mtvec = {$urandom(), $urandom()};
      bus.mepc  = {$urandom(), $urandom()};

      irq = bus.clint_mtip & bus.mstatus_mie & bus.mie_mtie;
      if (!m_act) begin
        any = 1'b1;
        m_ret = 1'b0;
        if (bus.wb_valid && bus.wb_ecall) begin
          m_cause = 64'd11;
          m_epc = bus.wb_pc;
        end else if (bus.wb_valid && bus.wb_ebreak) begin
          m_cause = 64'd3;
          m_epc = bus.wb_pc;
        end else if (bus.wb_valid && bus.wb_mret) begin
          m_ret = 1'b1;
          m_cause = '0;
          m_epc = '0;
        end else if (bus.wb_valid && irq) begin
          m_cause = MTI;
          m_epc = bus.wb_pc + 64'd4;
        end else begin
          any = 1'b0;
        end
        if (any) begin
          m_act = 1'b1;
          m_n = t;
          m_c = bus.mem_busy ? -1 : t + 1;
        end
      end else if (m_c < 0 && t > m_n && !bus.mem_busy) begin
        m_c = t + 1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
